if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Parametrised IF→ID pipeline register that replaces the bare flop stage with a two-entry skid buffer, valid/ready handshaking on both sides, and a synchronous flush for taken jumps/branches. It sits between the fetch unit and the decoder. It lets ID stall (hazard, multi-cycle decode) without dropping a fetched instruction, and without a combinational ready path from ID back to IF. When the stage is empty it presents a defined NOP encoding instead of unknown values.

## Interface
- INSTR_W, default 8: instruction width in bits.
- PC_W, default 8: program-counter width in bits.
- NOP_INSTR, default {INSTR_W{1'b0}}: encoding driven on id_instr whenever the stage holds no valid instruction.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- if_valid  input  1  IF presents an instruction this cycle.
- if_ready  output  1  stage can accept; registered, high iff skid entry is empty.
- if_instr  input  INSTR_W  fetched instruction.
- if_pc  input  PC_W  PC of the fetched instruction.
- flush  input  1  synchronous kill of all held and incoming instructions (taken jump/branch).
- id_valid  output  1  id_instr/id_pc hold a live instruction.
- id_ready  input  1  ID consumes the presented instruction this cycle.
- id_instr  output  INSTR_W  instruction to decode.
- id_pc  output  PC_W  PC forwarded with the instruction.
- occupancy  output  2  number of live entries held: 0, 1 or 2.

## Operation
- Storage has two entries. The main entry drives the id_* outputs. The skid entry catches one instruction accepted in the same cycle ID stalls.
- in_xfer = if_valid & if_ready.
- out_xfer = id_valid & id_ready.
- Next-state priority, evaluated each rising edge:
  1. rst low: see Timing.
  2. flush high:
     - main and skid entries become invalid.
     - id_instr <= NOP_INSTR; id_pc holds its value.
     - An instruction offered as in_xfer in the same cycle is discarded.
  3. Main entry empty, or out_xfer:
     - Skid valid: main <= skid and skid becomes empty. Here in_xfer cannot occur, because if_ready is low.
     - Else, in_xfer: main <= if_instr/if_pc.
     - Else: main becomes invalid and id_instr <= NOP_INSTR.
  4. Main entry valid, no out_xfer, in_xfer: skid <= if_instr/if_pc.
  5. Otherwise all entries hold.
- Data order is strictly FIFO; no instruction is duplicated or reordered.
- id_valid = main valid.
- if_ready = !skid valid.
- occupancy = main valid + skid valid. The skid entry is never valid while the main entry is empty.
- id_instr and id_pc are stable while id_valid & !id_ready. This is required by the handshake.
- The id_* outputs and if_ready are driven only from flops; there is no combinational path from id_ready to if_ready.

## Timing
- Reset (rst low, asynchronous, holds while low):
  - id_valid = 0, skid valid = 0, if_ready = 1 (registered, since skid valid = 0).
  - id_instr = NOP_INSTR, id_pc = 0, occupancy = 0.
  - Reset asserted mid-transfer drops all held instructions.
- Latency: an instruction accepted on edge N appears with id_valid = 1 after edge N.
- Throughput: one instruction per cycle with id_ready held high.
- Stall:
  - First stalled cycle with if_valid high: one extra instruction enters the skid entry.
  - if_ready falls after that edge.
  - if_ready rises one cycle after the first out_xfer that drains the skid.
- Flush:
  - After the edge: id_valid = 0, occupancy = 0, if_ready = 1.
  - The first post-flush instruction can be accepted in the cycle after the flush.
- flush with out_xfer in the same cycle: the consume completes from ID's view; the stage still empties.
- flush during reset: reset dominates.

## Test plan
- Reset with INSTR_W=8, PC_W=8, NOP_INSTR=8'h00: assert rst=0 mid-cycle -> immediately id_valid=0, id_instr=8'h00, id_pc=8'h00, occupancy=0, if_ready=1.
- Streaming: id_ready=1, feed instr 8'h11/pc 8'h00 through 8'h14/pc 8'h03 on consecutive cycles -> id_* show each pair exactly one cycle later, id_valid continuously 1, occupancy never exceeds 1.
- Stall/skid:
  - Stimulus: main holds 8'h21/pc 8'h10. Hold id_ready=0 while offering 8'h22/pc 8'h11, then 8'h23.
  - Required: 8'h22 is accepted and occupancy=2. if_ready=0, so 8'h23 is not accepted. id_* stay at 8'h21/8'h10.
  - Release id_ready: next id_* = 8'h22/8'h11, if_ready=1 one cycle later, then 8'h23 is accepted.
- Flush with full buffer: occupancy=2, assert flush with if_valid=1 carrying 8'h33 -> next cycle id_valid=0, id_instr=NOP_INSTR, id_pc unchanged, occupancy=0, if_ready=1, and 8'h33 never appears on id_*.
- Drain to empty: single instr 8'h44/pc 8'h20 consumed with no new input -> id_valid falls, id_instr=NOP_INSTR, id_pc=8'h20.
- Random: randomised if_valid/id_ready/flush (flush 5%) against a scoreboard FIFO cleared on flush -> order preserved, no loss or duplication, id_* stable while stalled.

Source files
------------

// File: rtl/if_id_skid_reg_if.sv
// IF->ID handshake bundle: fetch-side offer, decode-side presentation and flush.
// The slave modport is the pipeline register's view. The master modport is the surrounding pipeline's view.
interface if_id_skid_reg_if #(
  parameter int INSTR_W = 8,
  parameter int PC_W    = 8
);
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic [1:0]         occupancy;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, id_instr, id_pc, occupancy
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_instr, id_pc, occupancy
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register built as a two-entry skid buffer with synchronous flush.
// All outputs come from flops, so there is no combinational path from id_ready to if_ready.
module if_id_skid_reg #(
  parameter int                 INSTR_W   = 8,
  parameter int                 PC_W      = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic                clk,
  input  logic                rst,
  if_id_skid_reg_if.slave     bus
);

  logic               main_valid;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.if_valid & !skid_valid;
  assign out_xfer = main_valid & bus.id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (bus.flush) begin
      // id_pc is left holding the last presented PC
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_xfer) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
        main_instr <= bus.if_instr;
        main_pc    <= bus.if_pc;
      end else begin
        main_valid <= 1'b0;
        main_instr <= NOP_INSTR;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_instr <= bus.if_instr;
      skid_pc    <= bus.if_pc;
    end
  end

  assign bus.id_valid  = main_valid;
  assign bus.id_instr  = main_instr;
  assign bus.id_pc     = main_pc;
  assign bus.if_ready  = !skid_valid;
  assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed vector table, reset corner cases and a randomised scoreboard run for if_id_skid_reg.
module tb_if_id_skid_reg;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  if_id_skid_reg_if #(.INSTR_W(8), .PC_W(8)) bus ();

  if_id_skid_reg #(.INSTR_W(8), .PC_W(8), .NOP_INSTR(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] instr;
    logic [7:0] pc;
    logic       fl;
    logic       idr;
    logic       ev;
    logic [7:0] ei;
    logic [7:0] ep;
    logic [1:0] eo;
    logic       er;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [7:0] ei,
                         input logic [7:0] ep, input logic [1:0] eo, input logic er);
    chk({tag, ".id_valid"},  {31'd0, bus.id_valid}, {31'd0, ev});
    chk({tag, ".id_instr"},  {24'd0, bus.id_instr}, {24'd0, ei});
    chk({tag, ".id_pc"},     {24'd0, bus.id_pc},    {24'd0, ep});
    chk({tag, ".occupancy"}, {30'd0, bus.occupancy}, {30'd0, eo});
    chk({tag, ".if_ready"},  {31'd0, bus.if_ready}, {31'd0, er});
  endtask

  task automatic drive(input logic iv, input logic [7:0] instr, input logic [7:0] pc,
                       input logic fl, input logic idr);
    bus.if_valid = iv;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    bus.flush    = fl;
    bus.id_ready = idr;
  endtask

  // Scoreboard for the random phase
  logic [15:0] q[$];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    //          iv  instr  pc     fl   idr   ev   ei     ep     eo     er
    vt.push_back('{1'b1, 8'h11, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 8'h00, 2'd1, 1'b1});
    vt.push_back('{1'b1, 8'h12, 8'h01, 1'b0, 1'b1, 1'b1, 8'h12, 8'h01, 2'd1, 1'b1});
    vt.push_back('{1'b1, 8'h13, 8'h02, 1'b0, 1'b1, 1'b1, 8'h13, 8'h02, 2'd1, 1'b1});
    vt.push_back('{1'b1, 8'h14, 8'h03, 1'b0, 1'b1, 1'b1, 8'h14, 8'h03, 2'd1, 1'b1});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 2'd0, 1'b1});
    // stall / skid
    vt.push_back('{1'b1, 8'h21, 8'h10, 1'b0, 1'b0, 1'b1, 8'h21, 8'h10, 2'd1, 1'b1});
    vt.push_back('{1'b1, 8'h22, 8'h11, 1'b0, 1'b0, 1'b1, 8'h21, 8'h10, 2'd2, 1'b0});
    vt.push_back('{1'b1, 8'h23, 8'h12, 1'b0, 1'b0, 1'b1, 8'h21, 8'h10, 2'd2, 1'b0});
    vt.push_back('{1'b1, 8'h23, 8'h12, 1'b0, 1'b1, 1'b1, 8'h22, 8'h11, 2'd1, 1'b1});
    vt.push_back('{1'b1, 8'h23, 8'h12, 1'b0, 1'b1, 1'b1, 8'h23, 8'h12, 2'd1, 1'b1});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 2'd0, 1'b1});
    // flush with full buffer, incoming 8'h33 discarded
    vt.push_back('{1'b1, 8'h31, 8'h20, 1'b0, 1'b0, 1'b1, 8'h31, 8'h20, 2'd1, 1'b1});
    vt.push_back('{1'b1, 8'h32, 8'h21, 1'b0, 1'b0, 1'b1, 8'h31, 8'h20, 2'd2, 1'b0});
    vt.push_back('{1'b1, 8'h33, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 2'd0, 1'b1});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 2'd0, 1'b1});
    // flush while empty and ready: offered instruction still dropped
    vt.push_back('{1'b1, 8'h34, 8'h23, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 2'd0, 1'b1});
    vt.push_back('{1'b1, 8'h35, 8'h24, 1'b0, 1'b1, 1'b1, 8'h35, 8'h24, 2'd1, 1'b1});
    // flush together with out_xfer
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h24, 2'd0, 1'b1});
    // drain to empty
    vt.push_back('{1'b1, 8'h44, 8'h20, 1'b0, 1'b0, 1'b1, 8'h44, 8'h20, 2'd1, 1'b1});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 2'd0, 1'b1});

    #1;
    chk_all("reset0", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].iv, vt[i].instr, vt[i].pc, vt[i].fl, vt[i].idr);
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vt[i].ev, vt[i].ei, vt[i].ep, vt[i].eo, vt[i].er);
    end

    // asynchronous reset mid-cycle with a full buffer
    drive(1'b1, 8'h51, 8'h30, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 8'h52, 8'h31, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk_all("prefill", 1'b1, 8'h51, 8'h30, 2'd2, 1'b0);
    #2 rst = 1'b0;
    #1 chk_all("async_rst", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    // flush and an offer during reset: reset dominates
    drive(1'b1, 8'h53, 8'h32, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    chk_all("rst_hold", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_all("rst_release", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);

    // random phase against a FIFO scoreboard
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic       iv, idr, fl;
      logic [7:0] ri, rp;
      logic [15:0] hd;
      int          sz;
      sz = q.size();
      chk($sformatf("r%0d.occupancy", c), {30'd0, bus.occupancy}, sz);
      chk($sformatf("r%0d.if_ready", c), {31'd0, bus.if_ready}, {31'd0, (sz < 2)});
      chk($sformatf("r%0d.id_valid", c), {31'd0, bus.id_valid}, {31'd0, (sz > 0)});
      if (sz > 0) begin
        hd = q[0];
        chk($sformatf("r%0d.id_instr", c), {24'd0, bus.id_instr}, {24'd0, hd[15:8]});
        chk($sformatf("r%0d.id_pc", c), {24'd0, bus.id_pc}, {24'd0, hd[7:0]});
      end else begin
        chk($sformatf("r%0d.nop", c), {24'd0, bus.id_instr}, 32'd0);
      end
      iv  = ($urandom_range(0, 99) < 70);
      idr = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 99) < 5);
      ri  = 8'($urandom_range(0, 255));
      rp  = 8'(c);
      drive(iv, ri, rp, fl, idr);
      if (fl) begin
        q.delete();
      end else begin
        if (sz > 0 && idr) void'(q.pop_front());
        if (iv && sz < 2) q.push_back({ri, rp});
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
